// File: rtl/conv_output_stage.sv
// conv_output_stage: rounds, shifts and saturates accumulator window sums, tags them with raster addresses, and buffers them in a FIFO
// Ports: clk, rst (sync, active-high); frame_start pulse; acc_valid/acc_in/acc_ready input handshake;
//   out_valid/out_ready/out_data/out_addr/out_last output handshake; frame_done pulse; sticky sat_flag and drop_err.
// Optional macro CONV_OUT_RELU_EN: forces negative pixels to 0 after saturation.
module conv_output_stage #(
  parameter int DATA_WIDTH = 20,
  parameter int OUT_WIDTH  = 8,
  parameter int SHIFT      = 4,
  parameter int OUT_COLS   = 6,
  parameter int OUT_ROWS   = 6,
  parameter int ADDR_WIDTH = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  acc_valid,
  input  logic [DATA_WIDTH-1:0] acc_in,
  output logic                  acc_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  output logic                  frame_done,
  output logic                  sat_flag,
  output logic                  drop_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW1 = DATA_WIDTH + 1;
  localparam int TOTAL = OUT_ROWS * OUT_COLS;
  localparam logic [DATA_WIDTH:0] RND = DW1'(2 ** (SHIFT - 1));
  localparam logic signed [DATA_WIDTH:0] SMAX = DW1'(2 ** (OUT_WIDTH - 1) - 1);
  localparam logic signed [DATA_WIDTH:0] SMIN = DW1'(-(2 ** (OUT_WIDTH - 1)));
  localparam logic [OUT_WIDTH-1:0] PMAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] PMIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q;
  logic [ADDR_WIDTH-1:0] row_q, col_q, addr_d, pipe_addr_q;
  logic [OUT_WIDTH-1:0] pix_d, pipe_data_q;
  logic signed [DATA_WIDTH:0] t, s;
  logic last_d, accept, pop, ovf_hi, sat_hit;
  logic pipe_v_q, pipe_last_q, sat_q, drop_q;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] wr_q, rd_q;
  logic [OUT_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
  logic mem_last [FIFO_DEPTH];
  // Sign-extend one bit so adding the rounding constant cannot overflow; the arithmetic shift then rounds half up.
  assign t = {acc_in[DATA_WIDTH-1], acc_in} + RND;
  assign s = t >>> SHIFT;
  assign ovf_hi = s > SMAX;
`ifdef CONV_OUT_RELU_EN
  assign pix_d = s[DATA_WIDTH] ? '0 : ovf_hi ? PMAX : s[OUT_WIDTH-1:0];
  assign sat_hit = ovf_hi;
`else
  logic ovf_lo;
  assign ovf_lo = s < SMIN;
  assign pix_d = ovf_hi ? PMAX : ovf_lo ? PMIN : s[OUT_WIDTH-1:0];
  assign sat_hit = ovf_hi | ovf_lo;
`endif
  assign addr_d = ADDR_WIDTH'(int'(row_q) * OUT_COLS + int'(col_q));
  assign last_d = addr_d == ADDR_WIDTH'(TOTAL - 1);
  // The pipeline register counts as occupied so an accepted sample always finds FIFO room next cycle.
  assign acc_ready = (state_q == RUN) && ((int'(cnt_q) + int'(pipe_v_q)) < FIFO_DEPTH);
  assign accept = acc_valid && acc_ready;
  assign out_valid = cnt_q != '0;
  assign pop = out_valid && out_ready;
  assign out_data = out_valid ? mem_data[rd_q] : '0;
  assign out_addr = out_valid ? mem_addr[rd_q] : '0;
  assign out_last = out_valid && mem_last[rd_q];
  assign frame_done = state_q == DONE;
  assign sat_flag = sat_q;
  assign drop_err = drop_q;
  always_ff @(posedge clk) begin
    if (accept) begin
      pipe_data_q <= pix_d;
      pipe_addr_q <= addr_d;
      pipe_last_q <= last_d;
    end
    if (pipe_v_q) begin
      mem_data[wr_q] <= pipe_data_q;
      mem_addr[wr_q] <= pipe_addr_q;
      mem_last[wr_q] <= pipe_last_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q <= '0;
      col_q <= '0;
      pipe_v_q <= 1'b0;
      cnt_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      sat_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      pipe_v_q <= accept;
      if (pipe_v_q) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(pipe_v_q) - CW'(pop);
      if (accept) begin
        col_q <= (col_q == ADDR_WIDTH'(OUT_COLS - 1)) ? '0 : col_q + 1'b1;
        row_q <= (col_q == ADDR_WIDTH'(OUT_COLS - 1)) ? row_q + 1'b1 : row_q;
        if (sat_hit) sat_q <= 1'b1;
      end
      if (acc_valid && state_q == RUN && !acc_ready) drop_q <= 1'b1;
      case (state_q)
        IDLE: if (frame_start) begin
          state_q <= RUN;
          row_q <= '0;
          col_q <= '0;
          sat_q <= 1'b0;
          drop_q <= 1'b0;
        end
        RUN: if (accept && last_d) state_q <= DRAIN;
        DRAIN: if (!pipe_v_q && cnt_q == '0) state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/conv_output_stage.md
Name: conv_output_stage

Overview:
Downstream neighbour of the convolution accumulator. It captures each completed window sum, then rounds, shifts and saturates it to output pixel width. It tags each pixel with its raster output address and delivers it through a small FIFO over a valid/ready interface to the output buffer. Per-frame sequencing is handled by a 4-state FSM, which signals frame completion.

Parameters:
DATA_WIDTH, 20, width of the signed accumulator sum on acc_in
OUT_WIDTH, 8, width of the signed output pixel
SHIFT, 4, arithmetic right-shift (fixed-point rescale) applied before saturation; must be >= 1
OUT_COLS, 6, output feature-map width in pixels
OUT_ROWS, 6, output feature-map height in pixels
ADDR_WIDTH, 6, output address width; must satisfy 2^ADDR_WIDTH >= OUT_ROWS*OUT_COLS
FIFO_DEPTH, 4, output FIFO entries (power of two)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
frame_start  input  1  one-cycle pulse; starts a frame (honoured only in IDLE)
acc_valid  input  1  acc_in holds a final window sum this cycle
acc_in  input  DATA_WIDTH  signed window sum from accumulator
acc_ready  output  1  stage can accept acc_in this cycle
out_valid  output  1  out_data/out_addr/out_last valid
out_ready  input  1  output buffer accepts this cycle
out_data  output  OUT_WIDTH  signed processed pixel
out_addr  output  ADDR_WIDTH  raster address row*OUT_COLS+col
out_last  output  1  marks final pixel of frame
frame_done  output  1  one-cycle pulse when frame fully drained
sat_flag  output  1  sticky: any pixel this frame saturated
drop_err  output  1  sticky: acc_valid asserted while acc_ready low

Behaviour:
- Reset (rst=1 at clock edge), applied at any time including mid-frame:
  - FSM goes to IDLE; FIFO is emptied; pipeline register is invalidated; row/col counters are cleared.
  - Outputs: acc_ready=0, out_valid=0, out_data=0, out_addr=0, out_last=0, frame_done=0, sat_flag=0, drop_err=0.
- Input handshake:
  - Accept occurs when acc_valid && acc_ready.
  - acc_ready = (state==RUN) && (fifo_count + pipe_valid < FIFO_DEPTH).
  - acc_valid outside RUN is ignored and does not raise drop_err.
  - acc_valid in RUN with acc_ready=0 sets drop_err; the sample is lost.
- Arithmetic (pipeline stage 1, registered):
  - t = acc_in + 2^(SHIFT-1), computed in signed DATA_WIDTH+1 bits.
  - s = t >>> SHIFT (arithmetic shift; this gives round-half-up).
  - Saturate s to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Any clamp sets sat_flag.
- Addressing:
  - col increments on each accept; at OUT_COLS-1 col wraps to 0 and row increments.
  - out_last=1 for address OUT_ROWS*OUT_COLS-1.
- Stage 2: the pipeline register writes {data,addr,last} into the FIFO the following cycle.
  - Input-to-out_valid latency is 2 cycles with the FIFO empty and out_ready=1.
- Output side:
  - out_valid = FIFO non-empty.
  - Outputs show the FIFO head and are held stable while out_valid && !out_ready.
  - A pop occurs on out_valid && out_ready.
  - A simultaneous push and pop on a full FIFO is legal; count is unchanged.
- Throughput: 1 pixel/cycle sustained when out_ready=1.
- FSM:
  - IDLE: on frame_start, clear counters, sat_flag and drop_err, then go to RUN.
  - RUN: after the OUT_ROWS*OUT_COLS-th accept, go to DRAIN.
  - DRAIN: when pipe empty and FIFO empty, go to DONE.
  - DONE: assert frame_done for exactly 1 cycle, then go to IDLE.
  - frame_start outside IDLE is ignored.
  - If frame_start and a final-pixel accept occur together, the accept is processed and frame_start is ignored.
- sat_flag and drop_err hold through DONE and IDLE until the next frame_start or rst.

Optional Feature:
- Macro: CONV_OUT_RELU_EN.
- Defined: after saturation, negative results are forced to 0, so out_data is in [0, 2^(OUT_WIDTH-1)-1]. A negative clamp to 0 does not by itself set sat_flag; only positive overflow sets it.
- Undefined: signed saturated values pass unchanged.

Test Plan:
1. Rounding, defaults, out_ready=1, frame started. acc_in=53 → out_data=0x03, out_addr=0, out_valid 2 cycles after accept. acc_in=-40 → out_data=0xFE (0x00 with CONV_OUT_RELU_EN).
2. Saturation. acc_in=20'h7FFFF → 0x7F with sat_flag=1. acc_in=-4096 → 0x80. acc_in=-2000 → 0x83 with sat_flag unchanged by this sample.
3. Full frame. 36 back-to-back accepts, out_ready=1 → addresses 0..35 in order. out_last only on addr 35 (row 5, col 5). frame_done pulses once, 1 cycle after the FIFO drains. State returns to IDLE and acc_ready=0.
4. Backpressure. out_ready=0, acc_valid held high → exactly 4 accepts, then acc_ready=0 and drop_err=1. out_data held at the first pixel. Raising out_ready drains the 4 entries in order.
5. Protocol misuse. acc_valid in IDLE → no accept and drop_err stays 0. frame_start mid-RUN → ignored and counters continue.
6. Reset mid-frame. rst=1 after 10 accepts with 3 entries in the FIFO → next cycle out_valid=0, flags=0, state IDLE. A new frame_start then restarts at out_addr=0.
